// File: rtl/cxu_pkg.sv
// Shared definitions for the CXU MAC responder: function codes, status bit indices, FSM states.
// The MAC saturation helper is used only when CXU_MAC_SATURATE_EN is defined.
package cxu_pkg;

  localparam logic [2:0] FN_ADD    = 3'd0;
  localparam logic [2:0] FN_MUL    = 3'd1;
  localparam logic [2:0] FN_MAC    = 3'd2;
  localparam logic [2:0] FN_RDACC  = 3'd3;
  localparam logic [2:0] FN_CLRACC = 3'd4;

  localparam int ST_ILLEGAL   = 0;
  localparam int ST_BAD_CXU   = 1;
  localparam int ST_BAD_STATE = 2;
  localparam int ST_DROPPED   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } cxu_state_e;

  // The value fits in signed 32 bits only when bits [64:31] all agree.
  function automatic logic [31:0] sat32(input logic [64:0] s);
    if (s[64] && !(&s[63:31]))      return 32'h8000_0000;
    else if (!s[64] && (|s[63:31])) return 32'h7FFF_FFFF;
    else                            return s[31:0];
  endfunction

endpackage

// File: rtl/cxu_seq_mul.sv
// Iterative radix-2 signed 32x32->64 multiplier: sign-magnitude shift-add, 32 iterations.
// done is high during the cycle of the last iteration; product carries that iteration's result.
module cxu_seq_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [63:0] product
);

  logic        busy;
  logic [4:0]  cnt;
  logic        neg;
  logic [31:0] mcand;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [32:0] sum;
  logic [63:0] nxt;

  assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : 33'd0);
  assign nxt     = {sum, lo[31:1]};
  assign done    = busy && (cnt == 5'd31);
  assign product = neg ? -nxt : nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      neg   <= 1'b0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      neg   <= a[31] ^ b[31];
      mcand <= a[31] ? -a : a;
      lo    <= b[31] ? -b : b;
      hi    <= '0;
    end else if (busy) begin
      {hi, lo} <= nxt;
      cnt      <= cnt + 5'd1;
      if (cnt == 5'd31) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/cxu_mac_responder.sv
// CXU responder with ADD/MUL/MAC/RDACC/CLRACC over up to four accumulator states.
// Define CXU_MAC_SATURATE_EN to clamp MAC results to signed 32-bit limits instead of wrapping.
module cxu_mac_responder
  import cxu_pkg::*;
#(
  parameter logic [1:0] CXU_ID     = 2'd0,
  parameter int         NUM_STATES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cx_rst,
  input  logic        cx_req_valid,
  input  logic [1:0]  cx_cxu_id,
  input  logic [1:0]  cx_state_id,
  input  logic [24:0] cx_func,
  input  logic [31:0] cx_req_data0,
  input  logic [31:0] cx_req_data1,
  output logic        cx_resp_valid,
  output logic [31:0] cx_resp_data,
  output logic [3:0]  cx_resp_status,
  output logic        cx_resp_state
);

  cxu_state_e  state_q, state_d;
  logic [2:0]  func_q;
  logic [1:0]  sid_q;
  logic        drop_q;
  logic [31:0] acc_q [4];

  logic [2:0]  f;
  logic [2:0]  req_err;
  logic        is_mul_op;
  logic        accept;
  logic [31:0] imm_data;
  logic        imm_dirty;
  logic [31:0] mac_val;
  logic        mul_start;
  logic        mul_done;
  logic [63:0] mul_prod;
  logic        unused_func;

  assign f           = cx_func[2:0];
  assign unused_func = ^cx_func[24:3];
  assign is_mul_op   = (f == FN_MUL) || (f == FN_MAC);
  assign accept      = (state_q == IDLE) && cx_req_valid && !cx_rst;

  always_comb begin
    req_err               = '0;
    req_err[ST_ILLEGAL]   = f > FN_CLRACC;
    req_err[ST_BAD_CXU]   = cx_cxu_id != CXU_ID;
    req_err[ST_BAD_STATE] = int'(cx_state_id) >= NUM_STATES;
  end

  // Result for everything that answers one cycle after acceptance (including errors).
  always_comb begin
    imm_data  = '0;
    imm_dirty = !req_err[ST_BAD_STATE] && (acc_q[cx_state_id] != '0);
    if (req_err == '0) begin
      case (f)
        FN_ADD:    imm_data = cx_req_data0 + cx_req_data1;
        FN_RDACC:  imm_data = acc_q[cx_state_id];
        FN_CLRACC: imm_dirty = 1'b0;
        default:   ;
      endcase
    end
  end

`ifdef CXU_MAC_SATURATE_EN
  always_comb begin
    mac_val = sat32({{33{acc_q[sid_q][31]}}, acc_q[sid_q]} + {mul_prod[63], mul_prod});
  end
`else
  logic unused_prod_hi;
  assign unused_prod_hi = ^mul_prod[63:32];
  always_comb begin
    mac_val = acc_q[sid_q] + mul_prod[31:0];
  end
`endif

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    case (state_q)
      IDLE: if (cx_req_valid) begin
        if (req_err == '0 && is_mul_op) begin
          state_d   = MUL;
          mul_start = 1'b1;
        end else begin
          state_d = RESP;
        end
      end
      MUL:     if (mul_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (cx_rst) begin
      state_d   = IDLE;
      mul_start = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx_resp_valid  <= 1'b0;
      cx_resp_data   <= '0;
      cx_resp_status <= '0;
      cx_resp_state  <= 1'b0;
      drop_q         <= 1'b0;
      func_q         <= '0;
      sid_q          <= '0;
      for (int i = 0; i < 4; i++) acc_q[i] <= '0;
    end else if (cx_rst) begin
      // Soft clear: abort silently, response outputs keep their last values.
      cx_resp_valid <= 1'b0;
      drop_q        <= 1'b0;
      for (int i = 0; i < 4; i++) acc_q[i] <= '0;
    end else begin
      cx_resp_valid <= 1'b0;
      if (state_q != IDLE && cx_req_valid) drop_q <= 1'b1;
      if (accept) begin
        func_q <= f;
        sid_q  <= cx_state_id;
        if (req_err != '0 || !is_mul_op) begin
          cx_resp_valid  <= 1'b1;
          cx_resp_data   <= imm_data;
          cx_resp_status <= {drop_q, req_err};
          cx_resp_state  <= imm_dirty;
          drop_q         <= 1'b0;
          if (req_err == '0 && f == FN_CLRACC) acc_q[cx_state_id] <= '0;
        end
      end
      // A request dropped on the completing edge itself is still reported here.
      if (state_q == MUL && mul_done) begin
        cx_resp_valid  <= 1'b1;
        cx_resp_status <= {drop_q | cx_req_valid, 3'b000};
        drop_q         <= 1'b0;
        if (func_q == FN_MAC) begin
          cx_resp_data   <= mac_val;
          cx_resp_state  <= mac_val != '0;
          acc_q[sid_q]   <= mac_val;
        end else begin
          cx_resp_data   <= mul_prod[31:0];
          cx_resp_state  <= acc_q[sid_q] != '0;
        end
      end
    end
  end

  cxu_seq_mul u_mul (
    .clk     (clk),
    .rst     (rst),
    .abort   (cx_rst),
    .start   (mul_start),
    .a       (cx_req_data0),
    .b       (cx_req_data1),
    .done    (mul_done),
    .product (mul_prod)
  );

endmodule

// File: tb/tb_cxu_mac_responder.sv
// Scoreboard bench for cxu_mac_responder: directed cases plus randomized traffic against a
// behavioural model (accumulators, drop flag, fixed response latency).
module tb_cxu_mac_responder;

  localparam logic [1:0] ID = 2'd1;
  localparam int         NS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cx_rst = 1'b0;
  logic        cx_req_valid = 1'b0;
  logic [1:0]  cx_cxu_id = '0;
  logic [1:0]  cx_state_id = '0;
  logic [24:0] cx_func = '0;
  logic [31:0] cx_req_data0 = '0;
  logic [31:0] cx_req_data1 = '0;
  logic        cx_resp_valid;
  logic [31:0] cx_resp_data;
  logic [3:0]  cx_resp_status;
  logic        cx_resp_state;

  cxu_mac_responder #(.CXU_ID(ID), .NUM_STATES(NS)) dut (
    .clk(clk), .rst(rst), .cx_rst(cx_rst), .cx_req_valid(cx_req_valid),
    .cx_cxu_id(cx_cxu_id), .cx_state_id(cx_state_id), .cx_func(cx_func),
    .cx_req_data0(cx_req_data0), .cx_req_data1(cx_req_data1),
    .cx_resp_valid(cx_resp_valid), .cx_resp_data(cx_resp_data),
    .cx_resp_status(cx_resp_status), .cx_resp_state(cx_resp_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  st;
    logic        ds;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [31:0] macc [4];
  bit          drop_pend = 1'b0;
  logic [31:0] last_d = '0;
  logic [3:0]  last_st = '0;
  logic        last_ds = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every response, checks held outputs otherwise.
  always @(negedge clk) begin
    if (rst) begin
      last_d = '0; last_st = '0; last_ds = 1'b0;
    end else if (cx_resp_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_resp cyc=%0d data=%h status=%b", cyc, cx_resp_data, cx_resp_status);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (cx_resp_data !== e.d || cx_resp_status !== e.st || cx_resp_state !== e.ds || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL resp cyc=%0d data=%h status=%b state=%b, want cyc=%0d data=%h status=%b state=%b",
                   cyc, cx_resp_data, cx_resp_status, cx_resp_state, e.cyc, e.d, e.st, e.ds);
        end
      end
      last_d = cx_resp_data; last_st = cx_resp_status; last_ds = cx_resp_state;
    end else if (cx_resp_data !== last_d || cx_resp_status !== last_st || cx_resp_state !== last_ds) begin
      miscompares++;
      $display("FAIL hold cyc=%0d data=%h status=%b state=%b, want data=%h status=%b state=%b",
               cyc, cx_resp_data, cx_resp_status, cx_resp_state, last_d, last_st, last_ds);
      last_d = cx_resp_data; last_st = cx_resp_status; last_ds = cx_resp_state;
    end
  end

  function automatic logic [31:0] mac_model(input logic [31:0] acc, input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(acc)) + longint'($signed(a)) * longint'($signed(b));
`ifdef CXU_MAC_SATURATE_EN
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[31:0];
  endfunction

  task automatic drive_req(input logic [2:0] f, input logic [1:0] id, input logic [1:0] s,
                           input logic [31:0] a, input logic [31:0] b);
    cx_req_valid = 1'b1;
    cx_func      = {22'($urandom), f};
    cx_cxu_id    = id;
    cx_state_id  = s;
    cx_req_data0 = a;
    cx_req_data1 = b;
    @(posedge clk); #1;
    cx_req_valid = 1'b0;
  endtask

  // Issue one request from IDLE; stray>0 injects an extra request sampled stray edges later.
  task automatic issue(input logic [2:0] f, input logic [1:0] id, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] b, input int stray);
    exp_t   e;
    logic [2:0] err;
    int     lat;
    int     E;
    longint p;
    drive_req(f, id, s, a, b);
    E   = cyc;
    err = {int'(s) >= NS, id != ID, f > 3'd4};
    lat = (err == 3'b000 && (f == 3'd1 || f == 3'd2)) ? 32 : 0;
    e.d = '0;
    if (err == 3'b000) begin
      case (f)
        3'd0: e.d = a + b;
        3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); e.d = p[31:0]; end
        3'd2: begin macc[s] = mac_model(macc[s], a, b); e.d = macc[s]; end
        3'd3: e.d = macc[s];
        default: macc[s] = '0;
      endcase
    end
    e.st      = {drop_pend, err};
    drop_pend = 1'b0;
    e.ds      = (int'(s) < NS) ? (macc[s] != '0) : 1'b0;
    e.cyc     = E + lat;
    if (lat == 0) exp_q.push_back(e);
    for (int k = 1; k <= lat + 1; k++) begin
      if (stray == k) drive_req(3'($urandom), 2'($urandom), 2'($urandom), $urandom, $urandom);
      else begin @(posedge clk); #1; end
      if (stray == k) begin
        if (k <= lat) e.st[3] = 1'b1;
        else          drop_pend = 1'b1;
      end
      if (k == lat && lat > 0) exp_q.push_back(e);
    end
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 40)) - 32'd20;
      1:       return $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) macc[i] = '0;
    drop_pend = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  initial begin
    model_clear();
    #12;
    chk("rst_valid", 32'(cx_resp_valid), 32'd0);
    chk("rst_data", cx_resp_data, 32'd0);
    chk("rst_status", 32'(cx_resp_status), 32'd0);
    chk("rst_state", 32'(cx_resp_state), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Accepted on the first edge after reset release.
    issue(3'd0, ID, 2'd0, 32'hFFFF_FFFF, 32'd2, 0);
    issue(3'd1, ID, 2'd0, -32'sd3, 32'd7, 0);
    issue(3'd2, ID, 2'd1, 32'd5, 32'd6, 0);
    issue(3'd2, ID, 2'd1, 32'd2, -32'sd4, 0);
    issue(3'd3, ID, 2'd1, 32'd0, 32'd0, 0);
    issue(3'd4, ID, 2'd0, 32'd0, 32'd0, 0);
    issue(3'd2, ID, 2'd0, 32'h7FFF_FFF0, 32'd1, 0);
    issue(3'd2, ID, 2'd0, 32'd16, 32'd1, 0);
    issue(3'd1, ID, 2'd2, 32'd9, 32'd9, 5);
    issue(3'd6, 2'd3, 2'd0, 32'd1, 32'd1, 0);
    issue(3'd3, ID, 2'd3, 32'd0, 32'd0, 0);
    issue(3'd0, ID, 2'd0, 32'd1, 32'd1, 1);
    issue(3'd3, ID, 2'd1, 32'd0, 32'd0, 0);

    // Hard reset 10 cycles into a MAC: no response, accumulators cleared.
    drive_req(3'd2, ID, 2'd1, 32'd100, 32'd3);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    model_clear();
    #2;
    chk("midrst_valid", 32'(cx_resp_valid), 32'd0);
    chk("midrst_data", cx_resp_data, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    issue(3'd3, ID, 2'd1, 32'd0, 32'd0, 0);

    // Soft clear mid-MUL with a pending drop, then soft clear colliding with a request.
    issue(3'd2, ID, 2'd2, 32'd7, 32'd7, 0);
    drive_req(3'd1, ID, 2'd0, 32'd3, 32'd3);
    repeat (2) @(posedge clk);
    #1 cx_req_valid = 1'b1;
    @(posedge clk); #1 cx_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 cx_rst = 1'b1;
    @(posedge clk); #1 cx_rst = 1'b0;
    model_clear();
    cx_rst = 1'b1;
    drive_req(3'd0, ID, 2'd0, 32'd4, 32'd4);
    cx_rst = 1'b0;
    issue(3'd3, ID, 2'd2, 32'd0, 32'd0, 0);

    for (int n = 0; n < 60; n++) begin
      logic [2:0] f;
      logic [1:0] id;
      f  = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
      id = ($urandom_range(0, 7) == 0) ? 2'($urandom) : ID;
      issue(f, id, 2'($urandom_range(0, 3)), pick_op(), pick_op(),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 33)) : 0);
    end

    for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(posedge clk);
    repeat (3) @(posedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cxu_mac_responder.md
CXU_MAC_RESPONDER -- requirements
Module: cxu_mac_responder

Interface
REQ-001 SHALL have parameter CXU_ID, default 2'd0, the CXU identifier this responder answers to.
REQ-002 SHALL have parameter NUM_STATES, default 4 (range 1..4), the number of implemented accumulator states.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cx_rst  input  1  synchronous soft clear from the core.
REQ-006 SHALL have port cx_req_valid  input  1  request strobe, one cycle per request.
REQ-007 SHALL have port cx_cxu_id  input  2  target CXU.
REQ-008 SHALL have port cx_state_id  input  2  target accumulator state.
REQ-009 SHALL have port cx_func  input  25  function; only bits [2:0] are decoded, [24:3] are ignored.
REQ-010 SHALL have ports cx_req_data0 and cx_req_data1  input  32 each  operands A and B.
REQ-011 SHALL have port cx_resp_valid  output  1  one-cycle response strobe.
REQ-012 SHALL have port cx_resp_data  output  32  result.
REQ-013 SHALL have port cx_resp_status  output  4  error flags.
REQ-014 SHALL have port cx_resp_state  output  1  dirty flag of the targeted state.

Function
REQ-015 SHALL implement an FSM with states IDLE, MUL and RESP; IDLE -> RESP for single-cycle functions, IDLE -> MUL for MUL/MAC, MUL -> RESP after 32 iterations, RESP -> IDLE.
REQ-016 SHALL sample a request only in IDLE when cx_req_valid=1, latching all request fields.
REQ-017 SHALL decode func[2:0] as: 0 ADD, A+B mod 2^32; 1 MUL, low 32 bits of signed A*B; 2 MAC, acc[s] += signed A*B and return the new acc[s]; 3 RDACC, return acc[s]; 4 CLRACC, acc[s]=0 and return 0; 5..7 illegal.
REQ-018 SHALL assert cx_resp_valid for exactly one cycle, one cycle after acceptance for ADD/RDACC/CLRACC/errors and 33 cycles after acceptance for MUL/MAC.
REQ-019 SHALL hold cx_resp_data, cx_resp_status and cx_resp_state stable from the response cycle until the next response.
REQ-020 SHALL encode status as: [0] illegal func, [1] cx_cxu_id != CXU_ID, [2] cx_state_id >= NUM_STATES, [3] a request was dropped since the last response.
REQ-021 SHALL, when any of status[2:0] is set, respond after one cycle with data 0 and leave every accumulator unchanged.
REQ-022 SHALL drop any cx_req_valid seen outside IDLE, set a sticky drop flag, report it in status[3] of the next response, and clear the flag after that response.
REQ-023 SHALL drive cx_resp_state=1 when acc[s] is nonzero after the operation completes.
REQ-024 SHALL wrap MAC accumulation modulo 2^32 unless saturation is compiled in (REQ-030).
REQ-025 SHALL, on cx_rst=1, clear all accumulators and the drop flag, abort any in-flight operation without a response, and return to IDLE on the next edge; cx_rst takes priority over a simultaneous request.

Reset
REQ-026 SHALL, on rst=1, immediately force FSM=IDLE, cx_resp_valid=0, cx_resp_data=0, cx_resp_status=0, cx_resp_state=0, all accumulators to 0 and the drop flag to 0.
REQ-027 SHALL, when rst is asserted mid-operation, produce no response for the aborted request.
REQ-028 SHALL accept a request in the first cycle after rst deasserts.

Configuration
REQ-029 SHALL use the macro CXU_MAC_SATURATE_EN.
REQ-030 SHALL, with CXU_MAC_SATURATE_EN defined, clamp each MAC result to signed 32-bit limits (0x7FFFFFFF / 0x80000000), and without it wrap modulo 2^32; no other behaviour changes.

Structure
REQ-031 SHALL take the func codes, status bit indices and FSM state enum from shared package cxu_pkg.
REQ-032 SHALL instantiate sub-module cxu_seq_mul: an iterative radix-2 signed 32x32->64 multiplier with start/done, fixed at 32 cycles.

Verification
REQ-033 SHALL cover: ADD A=0xFFFFFFFF, B=2 -> resp_valid at +1, data=0x00000001, status=0.
REQ-034 SHALL cover: MUL A=-3, B=7 -> resp_valid at +33, data=0xFFFFFFEB, status=0.
REQ-035 SHALL cover: MAC on s=1 with (5,6) then (2,-4), then RDACC s=1 -> responses 30, 22, 22, with resp_state=1.
REQ-036 SHALL cover: MAC on s=0, acc=0x7FFFFFF0, with (16,1) -> data 0x7FFFFFFF when the macro is defined, 0x80000000 when it is not.
REQ-037 SHALL cover: a second request issued 5 cycles into a MUL -> the MUL response carries status[3]=1, and no response is produced for the dropped request.
REQ-038 SHALL cover: func=6 with a wrong cxu_id -> data 0 and status 4'b0011 at +1; rst asserted 10 cycles into a MAC -> no response, and a subsequent RDACC returns 0.
